// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad scanner.
//   state_e : debounce FSM states
//   pass_e  : classification of one full four-column scan pass
//   KeyMap  : hex code for each key, indexed [row][col]
//   first_low: index of the lowest set bit in a row-hit vector
package keypad_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StDebounce,
    StPressed,
    StRelease
  } state_e;

  typedef enum logic [1:0] {
    PassNone,
    PassSingle,
    PassMulti
  } pass_e;

  // Row 3 carries '*' as E and '#' as F so the codes match the display's hex space.
  localparam logic [3:0] KeyMap [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  // Lowest-index set bit; descending loop so the lowest row wins.
  function automatic logic [1:0] first_low(input logic [3:0] hits);
    first_low = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (hits[i]) first_low = 2'(i);
    end
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad-side and lock-controller-side signals of the keypad scanner.
//   row       : keypad rows, active-low, asynchronous
//   col       : keypad columns, active-low one-cold
//   key_code  : hex code of the last accepted key
//   key_valid : one-cycle pulse per accepted press
//   key_held  : high while the accepted key is considered pressed
// master = scanner side, slave = keypad/consumer side.
interface keypad_scanner_if;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (
    input  row,
    output col,
    output key_code,
    output key_valid,
    output key_held
  );

  modport slave (
    output row,
    input  col,
    input  key_code,
    input  key_valid,
    input  key_held
  );
endinterface

// File: rtl/scan_tick_gen.sv
// Free-running divider: tick is high for one clk whenever the count reaches TICKDIV-1.
//   clk   : system clock
//   reset : asynchronous active-low reset (count restarts at 0)
//   tick  : one-cycle strobe every TICKDIV clks
module scan_tick_gen #(
  parameter int unsigned TICKDIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CntW = (TICKDIV > 1) ? $clog2(TICKDIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TICKDIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = (cnt_q == CntMax);
    cnt_d = tick ? '0 : cnt_q + CntW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with debounce and hex encoding.
// Drives one column low per tick, samples synchronized rows, classifies each
// four-column pass as none/single/multi and debounces presses and releases
// over STABLESCANS consecutive passes.
//   clk   : system clock
//   reset : asynchronous active-low reset
//   kif   : row in, col / key_code / key_valid / key_held out
// TICKDIV = CLKFREQ/SCANFREQ must be >= 4; STABLESCANS must be >= 1.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned CLKFREQ     = 100_000_000,
  parameter int unsigned SCANFREQ    = 1000,
  parameter int unsigned STABLESCANS = 4
) (
  input  logic              clk,
  input  logic              reset,
  keypad_scanner_if.master  kif
);

  localparam int unsigned TickDiv = CLKFREQ / SCANFREQ;
  localparam int unsigned CntW    = $clog2(STABLESCANS + 1);
  localparam logic [CntW-1:0] StableCnt = CntW'(STABLESCANS);

  logic tick;

  scan_tick_gen #(
    .TICKDIV (TickDiv)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // Row synchronizer; idles high to match the external pull-ups.
  logic [3:0] row_meta_q, rs_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_meta_q <= 4'hF;
      rs_q       <= 4'hF;
    end else begin
      row_meta_q <= kif.row;
      rs_q       <= row_meta_q;
    end
  end

  // Column scan and per-pass accumulation.
  logic [1:0] col_idx_q, col_idx_d;
  logic [1:0] hits_q, hits_d;
  logic [1:0] first_row_q, first_row_d;
  logic [1:0] first_col_q, first_col_d;

  logic [3:0] low;
  logic [2:0] n_low, hit_sum;
  logic [1:0] prev_hits;
  logic       pass_end;
  pass_e      pass_res;
  logic [3:0] pass_key;

  always_comb begin
    low       = ~rs_q;
    n_low     = {2'b0, low[0]} + {2'b0, low[1]} + {2'b0, low[2]} + {2'b0, low[3]};
    // Column 0 starts a fresh pass.
    prev_hits = (col_idx_q == 2'd0) ? 2'd0 : hits_q;
    hit_sum   = {1'b0, prev_hits} + n_low;
    hits_d    = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];

    first_row_d = first_row_q;
    first_col_d = first_col_q;
    if (prev_hits == 2'd0 && low != 4'h0) begin
      first_row_d = first_low(low);
      first_col_d = col_idx_q;
    end

    col_idx_d = col_idx_q + 2'd1;
    pass_end  = tick && (col_idx_q == 2'd3);

    unique case (hits_d)
      2'd0:    pass_res = PassNone;
      2'd1:    pass_res = PassSingle;
      default: pass_res = PassMulti;
    endcase
    pass_key = KeyMap[first_row_d][first_col_d];

    kif.col = ~(4'b0001 << col_idx_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_idx_q   <= 2'd0;
      hits_q      <= 2'd0;
      first_row_q <= 2'd0;
      first_col_q <= 2'd0;
    end else if (tick) begin
      col_idx_q   <= col_idx_d;
      hits_q      <= hits_d;
      first_row_q <= first_row_d;
      first_col_q <= first_col_d;
    end
  end

  // Debounce FSM, evaluated only at the end of a pass.
  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [3:0]      cand_q, cand_d;
  logic [3:0]      key_code_q, key_code_d;
  logic            key_valid_q, key_valid_d;
  logic            key_held_q, key_held_d;
  logic            accept;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cand_d      = cand_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    accept      = 1'b0;
    cnt_inc     = cnt_q + CntW'(1);

    if (pass_end) begin
      case (state_q)
        StIdle: begin
          if (pass_res == PassSingle) begin
            cand_d = pass_key;
            cnt_d  = CntW'(1);
            if (STABLESCANS == 1) accept = 1'b1;
            else                  state_d = StDebounce;
          end
        end
        StDebounce: begin
          if (pass_res == PassSingle && pass_key == cand_q) begin
            if (cnt_inc == StableCnt) accept = 1'b1;
            else                      cnt_d  = cnt_inc;
          end else begin
            state_d = StIdle;
            cnt_d   = '0;
          end
        end
        StPressed: begin
          // Rollover and extra keys are ignored; only an empty pass starts a release.
          if (pass_res == PassNone) begin
            if (STABLESCANS == 1) begin
              state_d    = StIdle;
              cnt_d      = '0;
              key_held_d = 1'b0;
            end else begin
              state_d = StRelease;
              cnt_d   = CntW'(1);
            end
          end
        end
        StRelease: begin
          if (pass_res == PassNone) begin
            if (cnt_inc == StableCnt) begin
              state_d    = StIdle;
              cnt_d      = '0;
              key_held_d = 1'b0;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            state_d = StPressed;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end

    if (accept) begin
      state_d     = StPressed;
      cnt_d       = '0;
      key_code_d  = pass_key;
      key_valid_d = 1'b1;
      key_held_d  = 1'b1;
    end

    kif.key_code  = key_code_q;
    kif.key_valid = key_valid_q;
    kif.key_held  = key_held_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      cand_q      <= 4'h0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: TICKDIV=4 (16 clks/pass), STABLESCANS=3.
// A keypad model pulls a row low while its pressed key's column is driven low.
module tb_keypad_scanner;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  keypad_scanner_if kif ();

  keypad_scanner #(
    .CLKFREQ     (40),
    .SCANFREQ    (10),
    .STABLESCANS (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .kif   (kif)
  );

  // keys[r][c] = 1 while the key at row r, column c is pressed.
  logic [3:0][3:0] keys;
  logic [3:0]      row_drv;

  always_comb begin
    row_drv = 4'hF;
    for (int r = 0; r < 4; r++) row_drv[r] = ~|(keys[r] & ~kif.col);
  end
  assign kif.row = row_drv;

  int pulses = 0;
  always @(negedge clk) if (kif.key_valid === 1'b1) pulses++;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Wait for n pass ends (col stepping 0111 -> 1110); returns #1 after that edge.
  task automatic wait_passes(input int n);
    for (int p = 0; p < n; p++) begin
      logic       found;
      logic [3:0] c0;
      int         j;
      found = 1'b0;
      j     = 0;
      while (!found && j < 40) begin
        c0 = kif.col;
        @(posedge clk);
        #1;
        if (c0 == 4'b0111 && kif.col == 4'b1110) found = 1'b1;
        j++;
      end
      if (!found) check_eq("pass_timeout", {31'b0, found}, 32'd1);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_col"},   kif.col,       4'b1110);
    check_eq({tag, "_valid"}, kif.key_valid, 1'b0);
    check_eq({tag, "_held"},  kif.key_held,  1'b0);
    check_eq({tag, "_code"},  kif.key_code,  4'h0);
  endtask

  initial begin
    keys  = '0;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");

    // Column walk: four clks per column after release.
    @(negedge clk);
    reset = 1'b1;
    #1;
    for (int k = 0; k < 16; k++) begin
      logic [3:0] exp_col;
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      exp_col = ~(4'b0001 << (k / 4));
      check_eq($sformatf("col_walk%0d", k), kif.col, exp_col);
    end

    // Idle for 20 passes.
    wait_passes(20);
    check_eq("idle_pulses", pulses, 0);
    check_eq("idle_code", kif.key_code, 4'h0);
    check_eq("idle_held", kif.key_held, 1'b0);

    // '5' held for 6 passes.
    keys[1][1] = 1'b1;
    wait_passes(2);
    check_eq("k5_early_pulses", pulses, 0);
    check_eq("k5_early_held", kif.key_held, 1'b0);
    wait_passes(1);
    check_eq("k5_valid", kif.key_valid, 1'b1);
    check_eq("k5_held_rise", kif.key_held, 1'b1);
    check_eq("k5_code", kif.key_code, 4'h5);
    @(posedge clk);
    #1;
    check_eq("k5_valid_width", kif.key_valid, 1'b0);
    wait_passes(3);
    keys = '0;
    wait_passes(2);
    check_eq("k5_held_rel2", kif.key_held, 1'b1);
    wait_passes(1);
    check_eq("k5_held_rel3", kif.key_held, 1'b0);
    check_eq("k5_pulses", pulses, 1);

    // '#' for only 2 passes.
    keys[3][2] = 1'b1;
    wait_passes(2);
    keys = '0;
    wait_passes(3);
    check_eq("hash_pulses", pulses, 1);
    check_eq("hash_code", kif.key_code, 4'h5);

    // '*' bouncing: 2 on, 1 off, 4 on.
    keys[3][0] = 1'b1;
    wait_passes(2);
    keys = '0;
    wait_passes(1);
    keys[3][0] = 1'b1;
    wait_passes(2);
    check_eq("star_early_pulses", pulses, 1);
    wait_passes(1);
    check_eq("star_valid", kif.key_valid, 1'b1);
    check_eq("star_code", kif.key_code, 4'hE);
    wait_passes(1);
    // Release bounce: 2 empty, 1 contact.
    keys = '0;
    wait_passes(2);
    keys[3][0] = 1'b1;
    wait_passes(1);
    keys = '0;
    check_eq("star_recontact_held", kif.key_held, 1'b1);
    wait_passes(2);
    check_eq("star_rel2_held", kif.key_held, 1'b1);
    wait_passes(1);
    check_eq("star_rel3_held", kif.key_held, 1'b0);
    check_eq("star_pulses", pulses, 2);

    // '1' and 'A' together from idle.
    keys[0][0] = 1'b1;
    keys[0][3] = 1'b1;
    wait_passes(4);
    check_eq("multi_pulses", pulses, 2);
    check_eq("multi_held", kif.key_held, 1'b0);
    keys = '0;
    wait_passes(1);

    // 'D' accepted, then '3' added.
    keys[3][3] = 1'b1;
    wait_passes(3);
    check_eq("kd_valid", kif.key_valid, 1'b1);
    check_eq("kd_code", kif.key_code, 4'hD);
    keys[0][2] = 1'b1;
    wait_passes(3);
    check_eq("kd_roll_pulses", pulses, 3);
    check_eq("kd_roll_code", kif.key_code, 4'hD);
    check_eq("kd_roll_held", kif.key_held, 1'b1);
    keys = '0;
    wait_passes(3);
    check_eq("kd_rel_held", kif.key_held, 1'b0);

    // Reset mid-DEBOUNCE with '9' pressed.
    keys[2][2] = 1'b1;
    wait_passes(1);
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("rst_deb");
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    wait_passes(2);
    check_eq("k9_early_pulses", pulses, 3);
    check_eq("k9_early_held", kif.key_held, 1'b0);
    wait_passes(1);
    check_eq("k9_valid", kif.key_valid, 1'b1);
    check_eq("k9_code", kif.key_code, 4'h9);
    check_eq("k9_held", kif.key_held, 1'b1);

    // Reset mid-PRESSED.
    wait_passes(1);
    repeat (7) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("rst_prs");
    keys = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    wait_passes(4);
    check_eq("post_rst_held", kif.key_held, 1'b0);
    check_eq("post_rst_code", kif.key_code, 4'h0);
    check_eq("post_rst_pulses", pulses, 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Reads a 4x4 matrix keypad for the Security Device. Drives one column low at a time and samples the rows.
- Debounces the detected key and encodes it to a 4-bit hex code. The code is in the same hex space the seven-segment display path shows, so keypad input is the reading counterpart to display output.
- Emits a one-cycle key_valid pulse per accepted press, plus a held level, to the lock controller.

Parameters:
- CLKFREQ, 100_000_000, input clock frequency in Hz.
- SCANFREQ, 1000, column-step rate in Hz. TICKDIV = CLKFREQ/SCANFREQ; required TICKDIV >= 4.
- STABLESCANS, 4, consecutive full scan passes needed to accept a press or a release; required >= 1.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- row  input  4  keypad rows. Active-low, externally pulled up, asynchronous to clk.
- col  output  4  keypad columns. Active-low one-cold: exactly one bit is 0 at all times.
- key_code  output  4  hex code of the last accepted key.
- key_valid  output  1  one-clk pulse when a press is accepted.
- key_held  output  1  high while the accepted key is still considered pressed.

Behaviour:
- Reset (reset=0, asynchronous):
  - State = IDLE; all counters = 0.
  - col = 4'b1110; key_code = 4'h0; key_valid = 0; key_held = 0.
  - Applies mid-scan or mid-press with no residual pulse.
- Row synchronizer: row passes through a 2-flop synchronizer; rs is the output.
- Tick: a free-running counter 0..TICKDIV-1 produces tick=1 for one clk when the count equals TICKDIV-1.
- Column scan:
  - Column index c (0..3) wraps 3->0.
  - On tick: sample rs for column c, then advance c and set col = ~(4'b0001 << c_next).
  - Each column is therefore driven for TICKDIV clks before it is sampled.
- Pass:
  - A pass is the four samples c=0..3 and ends at the tick that samples c=3.
  - Per pass, track the hit count (number of low row bits, saturating at 2) and the first hit, scanned in column order then row ascending.
  - Pass result is exactly one of: NONE (0 hits), SINGLE(key), MULTI (2 or more hits).
- Key map, code[row][col]:
  - r0 = 1,2,3,A
  - r1 = 4,5,6,B
  - r2 = 7,8,9,C
  - r3 = E(*),0,F(#),D
- FSM (evaluated only at end of pass):
  - IDLE:
    - SINGLE(k) -> cand=k, cnt=1.
    - If STABLESCANS==1: accept immediately (same action as the DEBOUNCE accept). Otherwise -> DEBOUNCE.
    - NONE/MULTI: stay in IDLE.
  - DEBOUNCE:
    - SINGLE(cand): cnt+1. When cnt+1 == STABLESCANS: accept -> PRESSED, key_code <= code(cand), key_valid=1 for exactly one clk, key_held=1.
    - Any other result -> IDLE, cnt=0.
  - PRESSED:
    - NONE -> RELEASE, cnt=1; key_held stays 1.
    - SINGLE(cand) or MULTI or SINGLE(other): stay in PRESSED. Rollover is ignored; there is no new pulse until a release completes.
  - RELEASE:
    - NONE: cnt+1. When cnt+1 == STABLESCANS -> IDLE, key_held=0.
    - Any hit -> PRESSED, cnt=0; no key_valid.
- key_code holds its value until the next accepted press; it is never cleared except by reset.
- Latency: the first pass containing the key is counted as 1. key_valid is asserted in the clk after the end of pass STABLESCANS, worst case STABLESCANS+1 passes plus 2 sync clks after contact.
- key_valid and key_held are registered outputs.

Decomposition:
- Package keypad_pkg contains:
  - state typedef enum {IDLE, DEBOUNCE, PRESSED, RELEASE};
  - KEYMAP constant [4][4] of logic[3:0];
  - pass-result typedef {NONE, SINGLE, MULTI}.
- One sub-module, scan_tick_gen (TICKDIV parameter; clk, reset, tick). It is reusable as the async-active-low tick source.
- Synchronizer, scan and FSM stay in keypad_scanner.

Test Plan:
Bench parameters: CLKFREQ=40, SCANFREQ=10 (TICKDIV=4, 16 clks/pass), STABLESCANS=3.
- Reset released, no keys:
  - col cycles 1110,1101,1011,0111 with 4 clks each.
  - key_valid stays 0 and key_code = 0 for 20 passes.
- Hold '5' (row1 low whenever col=1101) for 6 passes:
  - exactly one key_valid pulse, key_code=4'h5;
  - key_held rises with the pulse and falls 3 passes after release.
- Hold '#' (row3 during col 1011) for only 2 passes, then release:
  - no key_valid; key_code unchanged.
- Bounce:
  - '*' present for 2 passes, absent 1, present 4 -> one pulse with key_code=4'hE, accepted on the 3rd consecutive pass of the final run.
  - Release with 1-pass re-contact after 2 empty passes -> still PRESSED, no second pulse.
- Two keys:
  - '1' and 'A' together from IDLE -> no pulse.
  - 'D' accepted, then '3' added -> no pulse; release all -> key_held=0.
- reset asserted mid-DEBOUNCE and mid-PRESSED:
  - outputs go immediately to col=1110, key_valid=0, key_held=0, key_code=0;
  - the FSM restarts in IDLE.
